car_sprite_scan: RTL
====================

Name: car_sprite_scan

Overview:
- Upstream stage of the car sprite fetch path; feeds the car RAM fetch stage.
- Converts the VGA scan position and the car screen position into sprite-sheet coordinates CarSpriteX/CarSpriteY.
- Selects the animation frame on the 404-px-wide sheet: 4 frames of 101 px (straight A, straight B, lean left, lean right).
- Emits a car_on flag delayed to line up with the fetch stage's 1-cycle colour index output.

Parameters:
- FRAME_W, 101, width in px of one sprite frame; sheet width = 4*FRAME_W = 404.
- SPRITE_H, 60, sprite height in px; must be ≤162.
- STEER_HOLD, 3, consecutive frame ticks a new steer value must persist before the lean frame changes.
- ANIM_DIV, 4, frame ticks per wheel-phase toggle.

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current scan column.
- DrawY  in  10  current scan row.
- vs  in  1  VGA vertical sync, active low.
- CarX  in  10  car sprite top-left column on screen.
- CarY  in  10  car sprite top-left row on screen.
- steer  in  2  01 = left, 10 = right, 00 or 11 = straight.
- moving  in  1  car speed nonzero; enables wheel animation.
- CarSpriteX  out  9  sheet column to the fetch stage.
- CarSpriteY  out  9  sheet row to the fetch stage.
- car_on  out  1  high when the colour index now leaving the fetch stage belongs to the car box.
- frame_sel  out  2  current frame number, for debug.

Behaviour:
- Reset (async assert, sync release): CarSpriteX = 0, CarSpriteY = 0, car_on = 0, frame_sel = 0.
  - Internal state: FSM = STRAIGHT, wheel phase = 0, hold counter = 0, anim counter = 0, vs_q = 1, car_on pipe = 0.
- Frame tick: one-cycle pulse when vs_q = 1 and vs = 0 (falling edge). vs_q is a register of vs.
- Box test (combinational, 11-bit unsigned compares, no wrap):
  - in_box = DrawX ≥ CarX && DrawX < CarX+FRAME_W && DrawY ≥ CarY && DrawY < CarY+SPRITE_H.
  - A box that runs past 639/479 is clipped naturally; nothing wraps.
- Coordinate register, 1 cycle:
  - If in_box: CarSpriteX <= frame_sel*FRAME_W + (DrawX-CarX), max 403; CarSpriteY <= DrawY-CarY.
  - Otherwise both load 0.
- car_on: in_box delayed 2 cycles (1 in this block + 1 RAM cycle in the fetch stage). Total DrawX-to-colour latency = 2 clk.
- Steer FSM (advances only on frame tick). States: STRAIGHT, LEAN_L, LEAN_R.
  - target = LEAN_L for steer 01, LEAN_R for 10, STRAIGHT otherwise.
  - target == state: hold counter <= 0.
  - target != state: hold counter increments. When it reaches STEER_HOLD-1, state <= target and counter <= 0.
  - Any change of target mid-count restarts the count from 1 against the new target.
  - LEAN_L ↔ LEAN_R switches directly; there is no forced pass through STRAIGHT.
- Wheel phase (frame tick only):
  - moving = 1: anim counter counts 0..ANIM_DIV-1; on wrap, phase toggles.
  - moving = 0: counter and phase hold.
- frame_sel: STRAIGHT → phase (0 or 1); LEAN_L → 2; LEAN_R → 3.
  - Registered on the frame tick only, so the frame never changes mid-screen.
- A steer or moving change on the tick cycle is sampled on that same cycle.
- CarX/CarY are used as they are each cycle; the producer must change them only during blanking.
- reset_n asserted mid-line: everything returns to reset values immediately; car_on drops in the same cycle.

Decomposition:
- car_pkg holds:
  - typedef enum steer_state_t {STRAIGHT, LEAN_L, LEAN_R}.
  - Constants SHEET_W = 404, FRAME_W = 101, FRAME_STRAIGHT_A/B = 0/1, FRAME_LEFT = 2, FRAME_RIGHT = 3.
- One sub-module, car_anim_ctrl: vs edge detect, steer FSM, wheel phase → frame_sel.
- The top level keeps the box test, the coordinate register and the car_on delay pipe.

Test Plan:
- Reset, CarX = 100, CarY = 50, steer = 00, sweep DrawX = 99..202 on DrawY = 50:
  - car_on is 0 for DrawX = 99 and 1 for DrawX = 100..200, each appearing 2 clk after its DrawX; 201 and 202 give 0.
  - CarSpriteX goes 0..100, 1 clk after its DrawX; CarSpriteY = 0.
- DrawY = 109 → CarSpriteY = 59, car_on = 1. DrawY = 110 → car_on = 0, CarSpriteY = 0.
- steer = 01 held, 3 vs falling edges → frame_sel = 2 after the 3rd tick. Pixel DrawX = 150 → CarSpriteX = 252.
- steer = 10 held 2 ticks then 00 → frame_sel stays at the straight phase. steer = 10 for 3 ticks → frame_sel = 3, pixel DrawX = 200 → CarSpriteX = 403.
- moving = 1, steer = 00, 8 ticks → frame_sel 0→1 after tick 4, →0 after tick 8. moving = 0 for 8 ticks → no change.
- reset_n low mid-box, DrawX = 150 → car_on = 0, CarSpriteX/Y = 0, frame_sel = 0 in the same cycle. After release, first in-box pixel has car_on = 1 2 clk later.

Source files
------------

// File: rtl/car_pkg.sv
// Shared types and constants for the car sprite fetch path.
// The sheet holds four 101-px frames side by side: straight A/B, lean left, lean right.
package car_pkg;

   typedef enum logic [1:0] {
      STRAIGHT = 2'd0,
      LEAN_L   = 2'd1,
      LEAN_R   = 2'd2
   } steer_state_t;

   localparam int SHEET_W = 404;
   localparam int FRAME_W = 101;

   localparam logic [1:0] FRAME_STRAIGHT_A = 2'd0;
   localparam logic [1:0] FRAME_STRAIGHT_B = 2'd1;
   localparam logic [1:0] FRAME_LEFT       = 2'd2;
   localparam logic [1:0] FRAME_RIGHT      = 2'd3;

   function automatic steer_state_t steer_target(input logic [1:0] steer);
      case (steer)
         2'b01:   return LEAN_L;
         2'b10:   return LEAN_R;
         default: return STRAIGHT;
      endcase
   endfunction

endpackage

// File: rtl/car_anim_ctrl.sv
// Per-frame animation control: vsync edge detect, debounced steer FSM and wheel phase.
// frame_sel only moves on the frame tick so a frame never changes mid-screen.
module car_anim_ctrl
   import car_pkg::*;
#(
   parameter int STEER_HOLD = 3,
   parameter int ANIM_DIV   = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       vs,
   input  logic [1:0] steer,
   input  logic       moving,
   output logic [1:0] frame_sel
);

   localparam int HOLD_W = (STEER_HOLD > 1) ? $clog2(STEER_HOLD) : 1;
   localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   steer_state_t      state_reg, state_next;
   steer_state_t      hold_target_reg, hold_target_next;
   logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic [ANIM_W-1:0] anim_cnt_reg, anim_cnt_next;
   logic              phase_reg, phase_next;
   logic [1:0]        frame_sel_reg, frame_sel_next;
   logic              vs_q_reg;
   logic              tick;
   steer_state_t      target;

   assign tick   = vs_q_reg & ~vs;
   assign target = steer_target(steer);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_q_reg        <= 1'b1;
         state_reg       <= STRAIGHT;
         hold_target_reg <= STRAIGHT;
         hold_cnt_reg    <= '0;
         anim_cnt_reg    <= '0;
         phase_reg       <= 1'b0;
         frame_sel_reg   <= FRAME_STRAIGHT_A;
      end else begin
         vs_q_reg        <= vs;
         state_reg       <= state_next;
         hold_target_reg <= hold_target_next;
         hold_cnt_reg    <= hold_cnt_next;
         anim_cnt_reg    <= anim_cnt_next;
         phase_reg       <= phase_next;
         frame_sel_reg   <= frame_sel_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      hold_target_next = hold_target_reg;
      hold_cnt_next    = hold_cnt_reg;
      anim_cnt_next    = anim_cnt_reg;
      phase_next       = phase_reg;
      frame_sel_next   = frame_sel_reg;

      if (tick) begin
         // A different target in the middle of a count counts as its first tick.
         if (target == state_reg) begin
            hold_cnt_next = '0;
         end else if (hold_cnt_reg != '0 && target != hold_target_reg) begin
            hold_cnt_next    = HOLD_W'(1);
            hold_target_next = target;
         end else if (hold_cnt_reg == HOLD_W'(STEER_HOLD - 1)) begin
            state_next    = target;
            hold_cnt_next = '0;
         end else begin
            hold_cnt_next    = hold_cnt_reg + 1'b1;
            hold_target_next = target;
         end

         if (moving) begin
            if (anim_cnt_reg == ANIM_W'(ANIM_DIV - 1)) begin
               anim_cnt_next = '0;
               phase_next    = ~phase_reg;
            end else begin
               anim_cnt_next = anim_cnt_reg + 1'b1;
            end
         end

         case (state_next)
            LEAN_L:  frame_sel_next = FRAME_LEFT;
            LEAN_R:  frame_sel_next = FRAME_RIGHT;
            default: frame_sel_next = phase_next ? FRAME_STRAIGHT_B : FRAME_STRAIGHT_A;
         endcase
      end
   end

   assign frame_sel = frame_sel_reg;

endmodule

// File: rtl/car_sprite_scan.sv
// Maps the scan position onto car sprite-sheet coordinates for the RAM fetch stage,
// with car_on delayed to line up with the fetch stage's registered colour index.
module car_sprite_scan #(
   parameter int FRAME_W    = car_pkg::FRAME_W,
   parameter int SPRITE_H   = 60,
   parameter int STEER_HOLD = 3,
   parameter int ANIM_DIV   = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       vs,
   input  logic [9:0] CarX,
   input  logic [9:0] CarY,
   input  logic [1:0] steer,
   input  logic       moving,
   output logic [8:0] CarSpriteX,
   output logic [8:0] CarSpriteY,
   output logic       car_on,
   output logic [1:0] frame_sel
);

   import car_pkg::*;

   localparam int SX_W     = $clog2(SHEET_W);
   localparam int ON_DELAY = 2;

   logic                in_box;
   logic [9:0]          dx, dy;
   logic [SX_W-1:0]     sprite_x_reg, sprite_x_next;
   logic [8:0]          sprite_y_reg, sprite_y_next;
   logic [ON_DELAY-1:0] on_pipe_reg;

   car_anim_ctrl #(
      .STEER_HOLD (STEER_HOLD),
      .ANIM_DIV   (ANIM_DIV)
   ) u_anim (
      .clk       (clk),
      .reset_n   (reset_n),
      .vs        (vs),
      .steer     (steer),
      .moving    (moving),
      .frame_sel (frame_sel)
   );

   // 11-bit compares so a box hanging off the right/bottom edge clips instead of wrapping.
   assign in_box = ({1'b0, DrawX} >= {1'b0, CarX}) &&
                   ({1'b0, DrawX} <  ({1'b0, CarX} + 11'(FRAME_W))) &&
                   ({1'b0, DrawY} >= {1'b0, CarY}) &&
                   ({1'b0, DrawY} <  ({1'b0, CarY} + 11'(SPRITE_H)));

   assign dx = DrawX - CarX;
   assign dy = DrawY - CarY;

   always_comb begin
      sprite_x_next = '0;
      sprite_y_next = '0;
      if (in_box) begin
         sprite_x_next = SX_W'(frame_sel) * SX_W'(FRAME_W) + SX_W'(dx);
         sprite_y_next = 9'(dy);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sprite_x_reg <= '0;
         sprite_y_reg <= '0;
         on_pipe_reg  <= '0;
      end else begin
         sprite_x_reg <= sprite_x_next;
         sprite_y_reg <= sprite_y_next;
         on_pipe_reg  <= {on_pipe_reg[ON_DELAY-2:0], in_box};
      end
   end

   assign CarSpriteX = 9'(sprite_x_reg);
   assign CarSpriteY = sprite_y_reg;
   assign car_on     = on_pipe_reg[ON_DELAY-1];

endmodule
